// File: rtl/bus_bridge_pkg.sv
// Shared types and default address map for the CPU-to-slave bus bridge.
// Holds the FSM state enum, the error read pattern and the 6-channel map.
package bus_bridge_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ACCESS,
    ST_RESP
  } state_t;

  localparam logic [31:0] ERR_RDATA = 32'hDEAD_BEEF;

  // ch5 timer, ch4 btn, ch3 sw, ch2 led, ch1 dig, ch0 DRAM
  localparam logic [6*32-1:0] BRIDGE_BASE_DEF = {
    32'hFFFF_F020, 32'hFFFF_F078, 32'hFFFF_F070,
    32'hFFFF_F060, 32'hFFFF_F000, 32'h0000_0000
  };

  localparam logic [6*32-1:0] BRIDGE_MASK_DEF = {
    32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'hFFFF_FFFC,
    32'hFFFF_FFFC, 32'hFFFF_FFFC, 32'hFFFC_0000
  };

endpackage

// File: rtl/bus_bridge_mc_if.sv
// CPU-side and slave-side signal bundle of the bus bridge.
// slave: bridge view; master: CPU/slave-model view driving the bridge.
interface bus_bridge_mc_if #(
  parameter int N_SLV  = 6,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic                    cpu_req;
  logic [ADDR_W-1:0]       cpu_addr;
  logic                    cpu_wen;
  logic [DATA_W-1:0]       cpu_wdata;
  logic [DATA_W-1:0]       cpu_rdata;
  logic                    cpu_ready;
  logic                    cpu_err;
  logic [N_SLV-1:0]        slv_sel;
  logic [ADDR_W-1:0]       slv_addr;
  logic                    slv_wen;
  logic [DATA_W-1:0]       slv_wdata;
  logic [N_SLV*DATA_W-1:0] slv_rdata;
  logic [N_SLV-1:0]        slv_ack;

  modport slave (
    input  cpu_req, cpu_addr, cpu_wen, cpu_wdata,
    input  slv_rdata, slv_ack,
    output cpu_rdata, cpu_ready, cpu_err,
    output slv_sel, slv_addr, slv_wen, slv_wdata
  );

  modport master (
    output cpu_req, cpu_addr, cpu_wen, cpu_wdata,
    output slv_rdata, slv_ack,
    input  cpu_rdata, cpu_ready, cpu_err,
    input  slv_sel, slv_addr, slv_wen, slv_wdata
  );
endinterface

// File: rtl/bus_addr_decoder.sv
// Combinational address decoder: addr -> one-hot channel + hit flag.
// Ports: addr in; onehot out (lowest matching index wins); hit out.
module bus_addr_decoder
  import bus_bridge_pkg::*;
#(
  parameter int                    N_SLV  = 6,
  parameter int                    ADDR_W = 32,
  parameter logic [N_SLV*ADDR_W-1:0] BASE = BRIDGE_BASE_DEF,
  parameter logic [N_SLV*ADDR_W-1:0] MASK = BRIDGE_MASK_DEF
) (
  input  logic [ADDR_W-1:0] addr,
  output logic [N_SLV-1:0]  onehot,
  output logic              hit
);

  always_comb begin
    onehot = '0;
    hit    = 1'b0;
    for (int i = 0; i < N_SLV; i++) begin
      if (!hit &&
          ((addr & MASK[i*ADDR_W +: ADDR_W]) ==
           (BASE[i*ADDR_W +: ADDR_W] & MASK[i*ADDR_W +: ADDR_W]))) begin
        onehot[i] = 1'b1;
        hit       = 1'b1;
      end
    end
  end

endmodule

// File: rtl/bus_bridge_mc.sv
// Multi-cycle CPU-to-slave bridge with address decode, ack wait and timeout.
// Ports: clk, rst_n (async, active-low), bus (bus_bridge_mc_if.slave).
module bus_bridge_mc
  import bus_bridge_pkg::*;
#(
  parameter int N_SLV   = 6,
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 15,
  parameter logic [N_SLV*ADDR_W-1:0] BASE = BRIDGE_BASE_DEF,
  parameter logic [N_SLV*ADDR_W-1:0] MASK = BRIDGE_MASK_DEF
) (
  input logic            clk,
  input logic            rst_n,
  bus_bridge_mc_if.slave bus
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);

  state_t              state;
  logic [CNT_W-1:0]    cnt;
  logic [N_SLV-1:0]    sel_q;
  logic [ADDR_W-1:0]   addr_q;
  logic                wen_q;
  logic [DATA_W-1:0]   wdata_q;
  logic [DATA_W-1:0]   rdata_q;
  logic                ready_q;
  logic                err_q;
  logic [N_SLV-1:0]    dec_oh;
  logic                dec_hit;
  logic                ack_sel;
  logic [DATA_W-1:0]   rd_mux;

  bus_addr_decoder #(
    .N_SLV  (N_SLV),
    .ADDR_W (ADDR_W),
    .BASE   (BASE),
    .MASK   (MASK)
  ) u_dec (
    .addr   (bus.cpu_addr),
    .onehot (dec_oh),
    .hit    (dec_hit)
  );

  // sel_q is one-hot, so an OR-mux picks the selected channel only
  always_comb begin
    ack_sel = |(bus.slv_ack & sel_q);
    rd_mux  = '0;
    for (int i = 0; i < N_SLV; i++) begin
      if (sel_q[i]) begin
        rd_mux = rd_mux | bus.slv_rdata[i*DATA_W +: DATA_W];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      cnt     <= '0;
      sel_q   <= '0;
      addr_q  <= '0;
      wen_q   <= 1'b0;
      wdata_q <= '0;
      rdata_q <= '0;
      ready_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      ready_q <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          if (bus.cpu_req) begin
            addr_q  <= bus.cpu_addr;
            wen_q   <= bus.cpu_wen;
            wdata_q <= bus.cpu_wdata;
            cnt     <= '0;
            if (dec_hit) begin
              state <= ST_ACCESS;
              sel_q <= dec_oh;
            end else begin
              state   <= ST_RESP;
              ready_q <= 1'b1;
              err_q   <= 1'b1;
              rdata_q <= DATA_W'(ERR_RDATA);
            end
          end
        end
        ST_ACCESS: begin
          if (cnt != CNT_W'(TIMEOUT)) begin
            cnt <= cnt + CNT_W'(1);
          end
          // ack checked first so a late ack beats the timeout
          if (ack_sel) begin
            state   <= ST_RESP;
            sel_q   <= '0;
            ready_q <= 1'b1;
            err_q   <= 1'b0;
            rdata_q <= wen_q ? '0 : rd_mux;
          end else if (cnt == CNT_W'(TIMEOUT - 1)) begin
            state   <= ST_RESP;
            sel_q   <= '0;
            ready_q <= 1'b1;
            err_q   <= 1'b1;
            rdata_q <= DATA_W'(ERR_RDATA);
          end
        end
        ST_RESP: begin
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
          sel_q <= '0;
        end
      endcase
    end
  end

  assign bus.slv_sel   = sel_q;
  assign bus.slv_addr  = addr_q;
  assign bus.slv_wen   = wen_q & (|sel_q);
  assign bus.slv_wdata = wdata_q;
  assign bus.cpu_rdata = rdata_q;
  assign bus.cpu_ready = ready_q;
  assign bus.cpu_err   = err_q;

endmodule

// File: tb/tb_bus_bridge_mc.sv
// Self-checking bench for bus_bridge_mc: vector table plus corner sequences.
// Drives at negedge, samples at negedge, i.e. away from the active edge.
module tb_bus_bridge_mc;

  localparam int NS = 6;

  logic clk;
  logic rst_n;
  int   n_chk;
  int   n_fail;

  bus_bridge_mc_if #(.N_SLV(NS), .ADDR_W(32), .DATA_W(32)) bus ();

  bus_bridge_mc #(
    .N_SLV   (NS),
    .ADDR_W  (32),
    .DATA_W  (32),
    .TIMEOUT (15)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [31:0] addr;
    logic        wen;
    logic [31:0] wdata;
    int          ch;
    int          dly;
    logic [31:0] rd;
    logic [5:0]  sel;
    int          len;
    logic        err;
    logic [31:0] erd;
  } vec_t;

  vec_t tv[11];

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic load_rdata(int ch, logic [31:0] rd);
    for (int i = 0; i < NS; i++) begin
      bus.slv_rdata[i*32 +: 32] = 32'hBAD0_0000 | 32'(i);
    end
    bus.slv_rdata[ch*32 +: 32] = rd;
  endtask

  task automatic run_vec(int id, vec_t v);
    bit done;
    done = 1'b0;
    @(negedge clk);
    load_rdata(v.ch, v.rd);
    bus.slv_ack   = '0;
    bus.cpu_req   = 1'b1;
    bus.cpu_addr  = v.addr;
    bus.cpu_wen   = v.wen;
    bus.cpu_wdata = v.wdata;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (k == 1) bus.cpu_req = 1'b0;
      if (k <= v.len) begin
        chk($sformatf("v%0d sel c%0d", id, k), 32'(bus.slv_sel), 32'(v.sel));
        chk($sformatf("v%0d wen c%0d", id, k), 32'(bus.slv_wen), 32'(v.wen));
        if (k == 1) begin
          chk($sformatf("v%0d slv_addr", id), bus.slv_addr, v.addr);
          chk($sformatf("v%0d slv_wdata", id), bus.slv_wdata, v.wdata);
        end
        bus.slv_ack = '0;
        if (k == v.dly + 1) bus.slv_ack[v.ch] = 1'b1;
      end else if (k == v.len + 1) begin
        bus.slv_ack = '0;
        chk($sformatf("v%0d ready", id), 32'(bus.cpu_ready), 32'd1);
        chk($sformatf("v%0d err", id), 32'(bus.cpu_err), 32'(v.err));
        chk($sformatf("v%0d rdata", id), bus.cpu_rdata, v.erd);
        chk($sformatf("v%0d sel@resp", id), 32'(bus.slv_sel), 32'd0);
      end else begin
        chk($sformatf("v%0d ready drop", id), 32'(bus.cpu_ready), 32'd0);
        done = 1'b1;
        break;
      end
    end
    if (!done) begin
      n_chk++;
      n_fail++;
      $display("FAIL v%0d budget: got no completion expected done", id);
    end
  endtask

  initial begin
    logic [15:0] seen;
    int          nrdy;
    n_chk  = 0;
    n_fail = 0;

    //          addr          wen   wdata         ch dly rd            sel        len err erd
    tv[0]  = '{32'h0000_0010, 1'b0, 32'h0,        0, 0,  32'h1234_5678, 6'b000001, 1,  1'b0, 32'h1234_5678};
    tv[1]  = '{32'hFFFF_F060, 1'b1, 32'h0000_00A5, 2, 3,  32'h7777_7777, 6'b000100, 4,  1'b0, 32'h0};
    tv[2]  = '{32'h8000_0000, 1'b0, 32'h0,        0, 0,  32'h0,         6'b000000, 0,  1'b1, 32'hDEAD_BEEF};
    tv[3]  = '{32'hFFFF_F070, 1'b0, 32'h0,        3, 99, 32'h3333_3333, 6'b001000, 15, 1'b1, 32'hDEAD_BEEF};
    tv[4]  = '{32'hFFFF_F078, 1'b0, 32'h0,        4, 1,  32'h0000_0001, 6'b010000, 2,  1'b0, 32'h0000_0001};
    tv[5]  = '{32'hFFFF_F024, 1'b0, 32'h0,        5, 0,  32'h0000_CAFE, 6'b100000, 1,  1'b0, 32'h0000_CAFE};
    tv[6]  = '{32'hFFFF_F000, 1'b1, 32'h0000_003F, 1, 2,  32'h5555_5555, 6'b000010, 3,  1'b0, 32'h0};
    tv[7]  = '{32'h0003_FFFC, 1'b0, 32'h0,        0, 0,  32'h0BAD_F00D, 6'b000001, 1,  1'b0, 32'h0BAD_F00D};
    tv[8]  = '{32'h0004_0000, 1'b0, 32'h0,        0, 0,  32'h0,         6'b000000, 0,  1'b1, 32'hDEAD_BEEF};
    tv[9]  = '{32'hFFFF_F070, 1'b0, 32'h0,        3, 14, 32'h0000_0E0E, 6'b001000, 15, 1'b0, 32'h0000_0E0E};
    tv[10] = '{32'hFFFF_F064, 1'b0, 32'h0,        0, 0,  32'h0,         6'b000000, 0,  1'b1, 32'hDEAD_BEEF};

    rst_n         = 1'b0;
    bus.cpu_req   = 1'b0;
    bus.cpu_addr  = '0;
    bus.cpu_wen   = 1'b0;
    bus.cpu_wdata = '0;
    bus.slv_ack   = '0;
    bus.slv_rdata = '0;
    #12;
    chk("rst sel", 32'(bus.slv_sel), 32'd0);
    chk("rst ready", 32'(bus.cpu_ready), 32'd0);
    chk("rst err", 32'(bus.cpu_err), 32'd0);
    chk("rst rdata", bus.cpu_rdata, 32'd0);
    chk("rst addr", bus.slv_addr, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 11; i++) begin
      run_vec(i, tv[i]);
    end

    // held request, back-to-back, with a spurious ch1 ack throughout
    @(negedge clk);
    load_rdata(0, 32'h0000_0011);
    bus.slv_ack   = 6'b000011;
    bus.cpu_req   = 1'b1;
    bus.cpu_addr  = 32'h0000_0020;
    bus.cpu_wen   = 1'b0;
    bus.cpu_wdata = '0;
    seen = '0;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      seen[k] = bus.cpu_ready;
      if (bus.cpu_ready) begin
        chk($sformatf("b2b rdata c%0d", k), bus.cpu_rdata, 32'h0000_0011);
      end
      if (k == 5) bus.cpu_req = 1'b0;
    end
    bus.slv_ack = '0;
    chk("b2b ready pattern", 32'(seen), 32'h0000_0024);

    // reset in the middle of a write access
    @(negedge clk);
    bus.cpu_req   = 1'b1;
    bus.cpu_addr  = 32'hFFFF_F070;
    bus.cpu_wen   = 1'b1;
    bus.cpu_wdata = 32'h0000_0055;
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      bus.cpu_req = 1'b0;
      chk($sformatf("rst-mid sel c%0d", k), 32'(bus.slv_sel), 32'h8);
    end
    rst_n = 1'b0;
    #1;
    chk("rst-mid sel", 32'(bus.slv_sel), 32'd0);
    chk("rst-mid wen", 32'(bus.slv_wen), 32'd0);
    chk("rst-mid addr", bus.slv_addr, 32'd0);
    chk("rst-mid wdata", bus.slv_wdata, 32'd0);
    chk("rst-mid ready", 32'(bus.cpu_ready), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    nrdy  = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (bus.cpu_ready) nrdy++;
    end
    chk("rst-mid no ready", 32'(nrdy), 32'd0);
    run_vec(11, tv[0]);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
